// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - oversampled UART receiver with multi-character frame assembly
module uart_rx_frame #(
  parameter int DATA_BITS = 8,
  parameter int OSR       = 8,
  parameter int NBYTES    = 4,
  parameter int IDLE_TO   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_clk,
  input  logic                          rxd,
  input  logic                          parity_en,
  input  logic                          parity_kind,
  output logic [NBYTES*DATA_BITS-1:0]   frame_data,
  output logic                          frame_valid,
  input  logic                          frame_ready,
  output logic                          frame_perr,
  output logic                          frame_ferr,
  output logic                          overrun
);

  localparam int FW        = NBYTES * DATA_BITS;
  localparam int TW        = $clog2(OSR);
  localparam int BW        = $clog2(DATA_BITS + 1);
  localparam int IXW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int IDLE_LIM  = IDLE_TO * OSR;
  localparam int IW        = (IDLE_LIM > 0) ? $clog2(IDLE_LIM + 1) : 1;
  localparam int IDLE_LAST = (IDLE_LIM > 0) ? IDLE_LIM - 1 : 0;

  localparam logic [TW-1:0]  HALF_M1   = TW'(OSR / 2 - 1);
  localparam logic [TW-1:0]  OSR_M1    = TW'(OSR - 1);
  localparam logic [BW-1:0]  BITS_M1   = BW'(DATA_BITS - 1);
  localparam logic [IXW-1:0] LAST_IDX  = IXW'(NBYTES - 1);
  localparam logic [IW-1:0]  IDLE_LAST_W = IW'(IDLE_LAST);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic                 rxd_meta_q, rxd_meta_d;
  logic                 rxd_s_q, rxd_s_d;
  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 pen_q, pen_d;
  logic                 pkind_q, pkind_d;
  logic                 cperr_q, cperr_d;
  logic                 wait_high_q, wait_high_d;
  logic [IXW-1:0]       idx_q, idx_d;
  logic [FW-1:0]        asm_q, asm_d;
  logic                 aperr_q, aperr_d;
  logic                 aferr_q, aferr_d;
  logic [IW-1:0]        idle_q, idle_d;
  logic                 cmpl_q, cmpl_d;
  logic                 cmpl_perr_q, cmpl_perr_d;
  logic                 cmpl_ferr_q, cmpl_ferr_d;
  logic                 valid_q, valid_d;
  logic [FW-1:0]        data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 accept;

  assign frame_data  = data_q;
  assign frame_valid = valid_q;
  assign frame_perr  = perr_q;
  assign frame_ferr  = ferr_q;
  assign overrun     = ovr_q;
  assign accept      = valid_q && frame_ready;

  // Two-stage synchroniser for the asynchronous line input
  always_comb begin
    rxd_meta_d = rxd;
    rxd_s_d    = rxd_meta_q;
  end

  // Character FSM, frame assembly and idle-timeout resync, advancing on sample ticks
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    pen_d       = pen_q;
    pkind_d     = pkind_q;
    cperr_d     = cperr_q;
    wait_high_d = wait_high_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    aperr_d     = aperr_q;
    aferr_d     = aferr_q;
    idle_d      = idle_q;
    cmpl_d      = 1'b0;
    cmpl_perr_d = cmpl_perr_q;
    cmpl_ferr_d = cmpl_ferr_q;
    if (sample_clk) begin
      case (state_q)
        S_IDLE: begin
          if (wait_high_q) begin
            // a low stop bit leaves the line low; it must go high before a new start
            if (rxd_s_q) wait_high_d = 1'b0;
          end else if (!rxd_s_q) begin
            state_d = S_START;
            tick_d  = TW'(1);
            idle_d  = '0;
          end
        end
        S_START: begin
          if (rxd_s_q) begin
            state_d = S_IDLE;
          end else if (tick_q == HALF_M1) begin
            state_d = S_DATA;
            tick_d  = '0;
            bit_d   = '0;
            pen_d   = parity_en;
            pkind_d = parity_kind;
            cperr_d = 1'b0;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tick_q == OSR_M1) begin
            tick_d  = '0;
            shreg_d = {rxd_s_q, shreg_q[DATA_BITS-1:1]};
            if (bit_q == BITS_M1) state_d = pen_q ? S_PARITY : S_STOP;
            else                  bit_d   = bit_q + 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (tick_q == OSR_M1) begin
            tick_d  = '0;
            cperr_d = rxd_s_q ^ (pkind_q ^ (^shreg_q));
            state_d = S_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_STOP: begin
          if (tick_q == OSR_M1) begin
            tick_d      = '0;
            state_d     = S_IDLE;
            wait_high_d = !rxd_s_q;
            for (int i = 0; i < NBYTES; i++) begin
              if (idx_q == IXW'(i)) asm_d[i*DATA_BITS +: DATA_BITS] = shreg_q;
            end
            if (idx_q == LAST_IDX) begin
              idx_d       = '0;
              cmpl_d      = 1'b1;
              cmpl_perr_d = aperr_q | cperr_q;
              cmpl_ferr_d = aferr_q | !rxd_s_q;
              aperr_d     = 1'b0;
              aferr_d     = 1'b0;
            end else begin
              idx_d   = idx_q + 1'b1;
              aperr_d = aperr_q | cperr_q;
              aferr_d = aferr_q | !rxd_s_q;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
      // a partial frame followed by a long idle line is abandoned
      if (IDLE_LIM > 0 && state_q == S_IDLE) begin
        if (idx_q == '0) begin
          idle_d = '0;
        end else if (rxd_s_q) begin
          if (idle_q == IDLE_LAST_W) begin
            idle_d  = '0;
            idx_d   = '0;
            aperr_d = 1'b0;
            aferr_d = 1'b0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
    end
  end

  // Output register with valid/ready handshake; a frame arriving while one is held is dropped
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    if (cmpl_q) begin
      if (!valid_q || accept) begin
        valid_d = 1'b1;
        data_d  = asm_q;
        perr_d  = cmpl_perr_q;
        ferr_d  = cmpl_ferr_q;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  // State registers; the synchroniser resets to the idle-high line level
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q  <= 1'b1;
      rxd_s_q     <= 1'b1;
      state_q     <= S_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      pen_q       <= 1'b0;
      pkind_q     <= 1'b0;
      cperr_q     <= 1'b0;
      wait_high_q <= 1'b0;
      idx_q       <= '0;
      asm_q       <= '0;
      aperr_q     <= 1'b0;
      aferr_q     <= 1'b0;
      idle_q      <= '0;
      cmpl_q      <= 1'b0;
      cmpl_perr_q <= 1'b0;
      cmpl_ferr_q <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      rxd_meta_q  <= rxd_meta_d;
      rxd_s_q     <= rxd_s_d;
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      pen_q       <= pen_d;
      pkind_q     <= pkind_d;
      cperr_q     <= cperr_d;
      wait_high_q <= wait_high_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      aperr_q     <= aperr_d;
      aferr_q     <= aferr_d;
      idle_q      <= idle_d;
      cmpl_q      <= cmpl_d;
      cmpl_perr_q <= cmpl_perr_d;
      cmpl_ferr_q <= cmpl_ferr_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - directed scoreboard bench for uart_rx_frame
module tb_uart_rx_frame;

  localparam int CLKS_PER_TICK = 4;
  localparam int CLKS_PER_BIT  = CLKS_PER_TICK * 8;

  typedef struct {
    logic [31:0] d;
    logic        perr;
    logic        ferr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_clk;
  logic        rxd;
  logic        parity_en;
  logic        parity_kind;
  logic [31:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic        frame_perr;
  logic        frame_ferr;
  logic        overrun;

  int   total  = 0;
  int   bad    = 0;
  int   nframes = 0;
  exp_t sb_q[$];

  uart_rx_frame #(.DATA_BITS(8), .OSR(8), .NBYTES(4), .IDLE_TO(16)) dut (
    .clk(clk), .rst(rst), .sample_clk(sample_clk), .rxd(rxd),
    .parity_en(parity_en), .parity_kind(parity_kind),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_perr(frame_perr), .frame_ferr(frame_ferr), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // oversample tick: one clk wide, every CLKS_PER_TICK clks
  initial begin
    sample_clk = 1'b0;
    forever begin
      repeat (CLKS_PER_TICK - 1) @(negedge clk);
      sample_clk = 1'b1;
      @(negedge clk);
      sample_clk = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [31:0] d, input logic perr, input logic ferr);
    exp_t e;
    e.d = d; e.perr = perr; e.ferr = ferr;
    sb_q.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (CLKS_PER_BIT) @(negedge clk);
  endtask

  task automatic send_char(input logic [7:0] d, input logic pen, input logic pbit, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (pen) send_bit(pbit);
    send_bit(stop);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk(tag, 64'(sb_q.size()), 64'd0);
  endtask

  // scoreboard: every accepted frame is compared with the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (frame_valid === 1'b1 && frame_ready === 1'b1) begin
        nframes++;
        total++;
        assert (sb_q.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_frame got=%0h exp=none", frame_data);
        end
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("frame_data", 64'(frame_data), 64'(e.d));
          chk("frame_perr", 64'(frame_perr), 64'(e.perr));
          chk("frame_ferr", 64'(frame_ferr), 64'(e.ferr));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; rxd = 1'b1; frame_ready = 1'b1; parity_en = 1'b0; parity_kind = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_valid", 64'(frame_valid), 64'd0);
    chk("rst_data", 64'(frame_data), 64'd0);
    chk("rst_perr", 64'(frame_perr), 64'd0);
    chk("rst_ferr", 64'(frame_ferr), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    rst = 1'b0;
    send_bit(1'b1); send_bit(1'b1);

    // 8N1 clean frame
    push_frame(32'h44332211, 1'b0, 1'b0);
    send_char(8'h11, 0, 0, 1); send_char(8'h22, 0, 0, 1);
    send_char(8'h33, 0, 0, 1); send_char(8'h44, 0, 0, 1);
    drain("drain_8n1");
    chk("one_frame", 64'(nframes), 64'd1);

    // odd parity, 0x3C sent with the wrong parity bit
    parity_en = 1'b1; parity_kind = 1'b1;
    push_frame(32'hFF013CA5, 1'b1, 1'b0);
    send_char(8'hA5, 1, ~(^8'hA5), 1);
    send_char(8'h3C, 1, ^8'h3C, 1);
    send_char(8'h01, 1, ~(^8'h01), 1);
    send_char(8'hFF, 1, ~(^8'hFF), 1);
    drain("drain_odd");

    // even parity, all correct
    parity_kind = 1'b0;
    push_frame(32'h80000703, 1'b0, 1'b0);
    send_char(8'h03, 1, ^8'h03, 1);
    send_char(8'h07, 1, ^8'h07, 1);
    send_char(8'h00, 1, ^8'h00, 1);
    send_char(8'h80, 1, ^8'h80, 1);
    drain("drain_even");
    parity_en = 1'b0;

    // low stop bit on char 2, line held low, then recovers
    push_frame(32'hDDCCBBAA, 1'b0, 1'b1);
    send_char(8'hAA, 0, 0, 1); send_char(8'hBB, 0, 0, 1);
    send_char(8'hCC, 0, 0, 0);
    send_bit(1'b0); send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b1);
    send_char(8'hDD, 0, 0, 1);
    drain("drain_ferr");
    chk("overrun_clear", 64'(overrun), 64'd0);

    // overrun: two frames while ready is low
    frame_ready = 1'b0;
    push_frame(32'h04030201, 1'b0, 1'b0);
    send_char(8'h01, 0, 0, 1); send_char(8'h02, 0, 0, 1);
    send_char(8'h03, 0, 0, 1); send_char(8'h04, 0, 0, 1);
    send_char(8'h05, 0, 0, 1); send_char(8'h06, 0, 0, 1);
    send_char(8'h07, 0, 0, 1); send_char(8'h08, 0, 0, 1);
    send_bit(1'b1);
    chk("held_valid", 64'(frame_valid), 64'd1);
    chk("held_data", 64'(frame_data), 64'h04030201);
    chk("overrun_set", 64'(overrun), 64'd1);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    #1;
    chk("valid_drop", 64'(frame_valid), 64'd0);
    drain("drain_overrun");
    frame_ready = 1'b1;

    // idle timeout discards a partial frame
    send_char(8'hE1, 0, 0, 1); send_char(8'hE2, 0, 0, 1);
    for (int i = 0; i < 20; i++) send_bit(1'b1);
    push_frame(32'hD4C3B2A1, 1'b0, 1'b0);
    send_char(8'hA1, 0, 0, 1); send_char(8'hB2, 0, 0, 1);
    send_char(8'hC3, 0, 0, 1); send_char(8'hD4, 0, 0, 1);
    drain("drain_timeout");

    // three-tick low glitch between characters is rejected
    push_frame(32'h9C9B9A99, 1'b0, 1'b0);
    send_char(8'h99, 0, 0, 1); send_char(8'h9A, 0, 0, 1); send_char(8'h9B, 0, 0, 1);
    rxd = 1'b0;
    repeat (3 * CLKS_PER_TICK) @(negedge clk);
    send_bit(1'b1); send_bit(1'b1);
    send_char(8'h9C, 0, 0, 1);
    drain("drain_glitch");

    // reset mid-character with one char already assembled and overrun still set
    send_char(8'h55, 0, 0, 1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    rxd = 1'b1;
    repeat (CLKS_PER_BIT / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_valid", 64'(frame_valid), 64'd0);
    chk("mid_rst_data", 64'(frame_data), 64'd0);
    chk("mid_rst_perr", 64'(frame_perr), 64'd0);
    chk("mid_rst_ferr", 64'(frame_ferr), 64'd0);
    chk("mid_rst_overrun", 64'(overrun), 64'd0);
    rst = 1'b0;
    send_bit(1'b1); send_bit(1'b1);
    push_frame(32'hF4F3F2F1, 1'b0, 1'b0);
    send_char(8'hF1, 0, 0, 1); send_char(8'hF2, 0, 0, 1);
    send_char(8'hF3, 0, 0, 1); send_char(8'hF4, 0, 0, 1);
    drain("drain_after_rst");

    chk("frame_count", 64'(nframes), 64'd8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
